// File: rtl/param_fifo_sv.sv
// Parameterized synchronous FIFO with registered read data, occupancy count,
// full/empty status and one-cycle overflow/underflow error pulses.
module param_fifo_sv #(
  parameter int unsigned W     = 8,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          wr_en,
  input  logic [W-1:0]  d_in,
  input  logic          rd_en,
  output logic [W-1:0]  d_out,
  output logic          empty,
  output logic          full,
  output logic [CW-1:0] count,
  output logic          overflow,
  output logic          underflow
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [CW-1:0] r_count;
  logic [W-1:0]  r_dout;
  logic          r_overflow;
  logic          r_underflow;

  logic          w_empty;
  logic          w_full;
  logic          w_push;
  logic          w_pop;
  logic [CW-1:0] w_count_d;

  // Status decode and accept conditions; a full FIFO still accepts a push
  // when a pop frees the oldest slot on the same edge.
  always_comb begin
    w_empty = (r_count == '0);
    w_full  = (r_count == CW'(DEPTH));
    w_push  = wr_en && (!w_full || rd_en);
    w_pop   = rd_en && !w_empty;
  end

  // Next occupancy: simultaneous push and pop leave the count unchanged.
  always_comb begin
    w_count_d = r_count;
    if (w_push && !w_pop) begin
      w_count_d = r_count + CW'(1);
    end else if (w_pop && !w_push) begin
      w_count_d = r_count - CW'(1);
    end
  end

  // Storage array; deliberately not reset.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= d_in;
    end
  end

  // Pointers, count, read data register and error pulses.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_count     <= '0;
      r_dout      <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + AW'(1);
      end
      // Non-blocking read sees the pre-edge entry even if the same slot is written.
      if (w_pop) begin
        r_dout <= r_mem[r_rptr];
        r_rptr <= r_rptr + AW'(1);
      end
      r_count     <= w_count_d;
      r_overflow  <= wr_en && !w_push;
      r_underflow <= rd_en && !w_pop;
    end
  end

  assign d_out     = r_dout;
  assign empty     = w_empty;
  assign full      = w_full;
  assign count     = r_count;
  assign overflow  = r_overflow;
  assign underflow = r_underflow;

endmodule

// File: tb/tb_param_fifo_sv.sv
// Self-checking bench for param_fifo_sv: queue-based reference model checked
// every cycle, plus directed vectors with literal expectations.
module tb_param_fifo_sv;

  localparam int unsigned W     = 8;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          resetn = 1'b1;
  logic          wr_en = 1'b0;
  logic          rd_en = 1'b0;
  logic [W-1:0]  d_in = '0;
  logic [W-1:0]  d_out;
  logic          empty;
  logic          full;
  logic [CW-1:0] count;
  logic          overflow;
  logic          underflow;

  int checks = 0;
  int errors = 0;

  param_fifo_sv #(.W(W), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .resetn   (resetn),
    .wr_en    (wr_en),
    .d_in     (d_in),
    .rd_en    (rd_en),
    .d_out    (d_out),
    .empty    (empty),
    .full     (full),
    .count    (count),
    .overflow (overflow),
    .underflow(underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a queue of stored words plus the last popped word.
  logic [W-1:0] q[$];
  logic [W-1:0] m_dout = '0;
  logic         m_ovf = 1'b0;
  logic         m_unf = 1'b0;

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      q.delete();
      m_dout = '0;
      m_ovf  = 1'b0;
      m_unf  = 1'b0;
    end else begin
      bit push_ok;
      bit pop_ok;
      push_ok = wr_en && ((q.size() < DEPTH) || rd_en);
      pop_ok  = rd_en && (q.size() > 0);
      if (pop_ok) m_dout = q.pop_front();
      if (push_ok) q.push_back(d_in);
      m_ovf = wr_en && !push_ok;
      m_unf = rd_en && !pop_ok;
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    chk("cmp_dout", 32'(d_out), 32'(m_dout));
    chk("cmp_count", 32'(count), q.size());
    chk("cmp_empty", 32'(empty), 32'(q.size() == 0));
    chk("cmp_full", 32'(full), 32'(q.size() == DEPTH));
    chk("cmp_overflow", 32'(overflow), 32'(m_ovf));
    chk("cmp_underflow", 32'(underflow), 32'(m_unf));
  end

  task automatic step(input logic w, input logic r, input logic [W-1:0] d);
    wr_en = w;
    rd_en = r;
    d_in  = d;
    @(posedge clk);
    #1;
  endtask

  logic [W-1:0] stream [10];
  int           pops;

  initial begin
    #1 resetn = 1'b0;
    for (int i = 0; i < 7; i++) begin
      @(posedge clk);
      #1;
      chk("rst_empty", 32'(empty), 32'd1);
      chk("rst_full", 32'(full), 32'd0);
      chk("rst_count", 32'(count), 32'd0);
      chk("rst_dout", 32'(d_out), 32'h00);
    end
    resetn = 1'b1;

    // Fill.
    step(1, 0, 8'h11);
    chk("push1_count", 32'(count), 32'd1);
    chk("push1_empty", 32'(empty), 32'd0);
    step(1, 0, 8'h22);
    step(1, 0, 8'h33);
    step(1, 0, 8'h44);
    chk("fill_full", 32'(full), 32'd1);
    chk("fill_count", 32'(count), 32'd4);

    // Overflow while full.
    step(1, 0, 8'h55);
    chk("ovf_pulse", 32'(overflow), 32'd1);
    chk("ovf_count", 32'(count), 32'd4);
    step(0, 0, 8'h00);
    chk("ovf_clear", 32'(overflow), 32'd0);

    // Drain.
    step(0, 1, 8'h00);
    chk("drain_1", 32'(d_out), 32'h11);
    step(0, 1, 8'h00);
    chk("drain_2", 32'(d_out), 32'h22);
    step(0, 1, 8'h00);
    chk("drain_3", 32'(d_out), 32'h33);
    step(0, 1, 8'h00);
    chk("drain_4", 32'(d_out), 32'h44);
    chk("drain_empty", 32'(empty), 32'd1);

    // Underflow when empty.
    step(0, 1, 8'h00);
    chk("unf_pulse", 32'(underflow), 32'd1);
    chk("unf_dout_hold", 32'(d_out), 32'h44);
    step(0, 0, 8'h00);
    chk("unf_clear", 32'(underflow), 32'd0);

    // Simultaneous push/pop while full.
    step(1, 0, 8'h11);
    step(1, 0, 8'h22);
    step(1, 0, 8'h33);
    step(1, 0, 8'h44);
    step(1, 1, 8'h66);
    chk("full_both_dout", 32'(d_out), 32'h11);
    chk("full_both_count", 32'(count), 32'd4);
    chk("full_both_ovf", 32'(overflow), 32'd0);
    step(0, 1, 8'h00);
    chk("after_both_1", 32'(d_out), 32'h22);
    step(0, 1, 8'h00);
    chk("after_both_2", 32'(d_out), 32'h33);
    step(0, 1, 8'h00);
    chk("after_both_3", 32'(d_out), 32'h44);
    step(0, 1, 8'h00);
    chk("after_both_4", 32'(d_out), 32'h66);

    // Simultaneous push/pop while empty: no bypass.
    step(1, 1, 8'h77);
    chk("empty_both_unf", 32'(underflow), 32'd1);
    chk("empty_both_count", 32'(count), 32'd1);
    chk("empty_both_dout", 32'(d_out), 32'h66);
    step(0, 1, 8'h00);
    chk("empty_both_pop", 32'(d_out), 32'h77);

    // Continuous stream across pointer wraps.
    for (int i = 0; i < 10; i++) stream[i] = W'($urandom);
    pops = 0;
    step(1, 0, stream[0]);
    for (int i = 1; i < 10; i++) begin
      step(1, 1, stream[i]);
      chk("stream_order", 32'(d_out), 32'(stream[pops]));
      pops++;
      chk("stream_count", 32'(count), 32'd1);
    end
    step(0, 1, 8'h00);
    chk("stream_last", 32'(d_out), 32'(stream[9]));
    chk("stream_empty", 32'(empty), 32'd1);

    // Async reset asserted mid-stream between edges.
    step(1, 0, 8'hA1);
    step(1, 0, 8'hB2);
    step(1, 1, 8'hC3);
    chk("pre_rst_dout", 32'(d_out), 32'hA1);
    wr_en = 1'b1;
    rd_en = 1'b1;
    d_in  = 8'hD4;
    #2 resetn = 1'b0;
    #1;
    chk("mid_rst_dout", 32'(d_out), 32'h00);
    chk("mid_rst_count", 32'(count), 32'd0);
    chk("mid_rst_empty", 32'(empty), 32'd1);
    chk("mid_rst_full", 32'(full), 32'd0);
    chk("mid_rst_ovf", 32'(overflow), 32'd0);
    chk("mid_rst_unf", 32'(underflow), 32'd0);
    @(posedge clk);
    #1;
    chk("hold_rst_count", 32'(count), 32'd0);
    wr_en  = 1'b0;
    rd_en  = 1'b0;
    resetn = 1'b1;
    step(0, 0, 8'h00);
    chk("post_rst_empty", 32'(empty), 32'd1);
    step(1, 0, 8'hE5);
    step(0, 1, 8'h00);
    chk("post_rst_pop", 32'(d_out), 32'hE5);
    step(0, 0, 8'h00);

    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    errors++;
    $display("FAIL watchdog got timeout expected finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/param_fifo_sv.md
# param_fifo_sv

Parameterized synchronous FIFO that buffers a byte stream ahead of the parameterized register stage. A producer pushes words with `wr_en` and the consumer pops them with `rd_en`. The registered `d_out` of this block drives the register stage's `d_in` directly. Full/empty/count status and one-cycle overflow/underflow error pulses are provided for flow control and debug.

## Interface
- `W`, default 8: data width in bits; must match the downstream register width.
- `DEPTH`, default 4: number of storage entries; power of two, at least 2.
- `CW`, default `$clog2(DEPTH)+1`: width of `count`; derived, not overridden.

- `clk`, input, 1: clock; all state changes on the rising edge.
- `resetn`, input, 1: reset, asynchronous, active-low. One clock; reset is asynchronous and active-low.
- `wr_en`, input, 1: push request for `d_in`.
- `d_in`, input, W: write data.
- `rd_en`, input, 1: pop request.
- `d_out`, output, W: registered read data.
- `empty`, output, 1: no entries stored.
- `full`, output, 1: DEPTH entries stored.
- `count`, output, CW: number of entries stored, 0..DEPTH.
- `overflow`, output, 1: one-cycle pulse, push rejected.
- `underflow`, output, 1: one-cycle pulse, pop rejected.

## Operation
- Storage: DEPTH x W memory.
- Pointers: write and read pointers, each `$clog2(DEPTH)` bits, wrap naturally from DEPTH-1 to 0.
- Occupancy: a `count` register is the single source of truth. `empty` = (count==0) and `full` = (count==DEPTH), both decoded combinationally from the `count` register.
- Push accepted when `wr_en && (!full || rd_en)`:
  - mem[wptr] <= d_in; wptr increments.
- Pop accepted when `rd_en && !empty`:
  - d_out <= mem[rptr]; rptr increments.
- Count update:
  - +1 on push only.
  - -1 on pop only.
  - Unchanged on both or neither.
- Simultaneous push and pop when full: both accepted, count stays DEPTH. The pop reads the oldest entry before the write slot is reused.
- Simultaneous push and pop when empty: push accepted, pop rejected. `underflow` pulses and count becomes 1. There is no bypass of the written word to `d_out`.
- Push when full without pop: data dropped, pointers and count unchanged, `overflow`=1 for that cycle.
- Pop when empty: `d_out` holds its value, `underflow`=1 for that cycle.
- `d_out` holds its last popped value whenever no pop is accepted.
- Memory contents are not reset; only pointers, count, `d_out` and the pulse outputs are.

## Timing
- Reset values, applied asynchronously while `resetn`=0:
  - `d_out`=0, `empty`=1, `full`=0, `count`=0, `overflow`=0, `underflow`=0.
  - Pointers = 0.
- Release: the first edge with `resetn`=1 is operative. No synchronizer is required inside the block.
- Push latency: a push sampled at edge N updates `count`/`empty`/`full` immediately after edge N.
- Pop latency: a pop sampled at edge N presents data on `d_out` immediately after edge N, so 1-cycle read latency.
- Minimum write-to-output latency: 2 edges (push at N, pop at N+1, data valid after N+1).
- Throughput: one push and one pop per cycle, sustained.
- `overflow`/`underflow` are registered. They assert for exactly one cycle after the offending edge and reassert on each consecutive offending edge.
- Reset mid-operation: all stored entries are discarded and outputs return to reset values within the same cycle. After release the FIFO is empty.

## Test plan
- Reset check: hold `resetn`=0 for 7 cycles -> `empty`=1, `full`=0, `count`=0, `d_out`=00 throughout.
- Fill and drain, DEPTH=4:
  - Push 11, 22, 33, 44 on consecutive edges -> `full`=1 and `count`=4 after the 4th edge.
  - Pop 4 times -> `d_out` = 11, 22, 33, 44 in order; `empty`=1 after the last pop.
- Overflow: when full, push 55 without `rd_en` -> `overflow`=1 for one cycle, `count` stays 4, later pops still return 11..44 with no 55.
- Underflow: when empty with `d_out`=44, assert `rd_en` -> `underflow`=1 for one cycle, `d_out` stays 44.
- Simultaneous edge cases:
  - Full with `wr_en` and `rd_en` both high, `d_in`=66 -> `d_out`=11, count stays 4, 66 returned after 22, 33, 44.
  - Empty with both high, `d_in`=77 -> `underflow`=1, `count`=1, next pop returns 77.
- Wrap-around and async reset:
  - Stream 10 `$random` words with continuous push/pop over 3 pointer wraps -> output order equals input order.
  - Assert `resetn`=0 mid-stream between edges -> outputs reach reset values before the next edge.
